// File: rtl/rgb_led_pwm_fader.sv
// RGB LED output stage: accepts colour commands over valid/ready, applies or ramps
// them per channel, and drives glitch-free PWM on the three LED pins.
module rgb_led_pwm_fader #(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 256,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3*PWM_BITS-1:0] cmd_rgb,
  input  logic                  cmd_fade,
  output logic                  busy,
  output logic [3*PWM_BITS-1:0] cur_rgb,
  output logic [2:0]            led_rgb
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic {IDLE, FADE} state_e;

  state_e                state_q, state_d;
  logic [3*PWM_BITS-1:0] cur_q, cur_d;
  logic [3*PWM_BITS-1:0] target_q, target_d;
  logic [3*PWM_BITS-1:0] shadow_q;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [PS_W-1:0]       ps_q, ps_d;
  logic [2:0]            led_q;
  logic                  xfer;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == FADE);
  assign cur_rgb   = cur_q;
  assign led_rgb   = led_q;
  assign xfer      = cmd_valid && cmd_ready;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    target_d = target_q;
    ps_d     = ps_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (!cmd_fade) begin
            cur_d = cmd_rgb;
          end else if (cmd_rgb != cur_q) begin
            target_d = cmd_rgb;
            ps_d     = '0;
            state_d  = FADE;
          end
        end
      end
      FADE: begin
        // Exit is decided on the registered cur, one cycle after the final step.
        if (cur_q == target_q) begin
          state_d = IDLE;
        end else if (ps_q == PS_MAX) begin
          ps_d = '0;
          for (int unsigned c = 0; c < 3; c++) begin
            if (cur_q[c*PWM_BITS +: PWM_BITS] < target_q[c*PWM_BITS +: PWM_BITS])
              cur_d[c*PWM_BITS +: PWM_BITS] = cur_q[c*PWM_BITS +: PWM_BITS] + PWM_BITS'(1);
            else if (cur_q[c*PWM_BITS +: PWM_BITS] > target_q[c*PWM_BITS +: PWM_BITS])
              cur_d[c*PWM_BITS +: PWM_BITS] = cur_q[c*PWM_BITS +: PWM_BITS] - PWM_BITS'(1);
          end
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      target_q <= '0;
      ps_q     <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      ps_q     <= ps_d;
    end
  end

  // Shadow duty only changes at the period boundary, so a period is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      shadow_q  <= '0;
      led_q     <= {3{ACTIVE_LOW}};
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (pwm_cnt_q == '1)
        shadow_q <= cur_q;
      for (int unsigned c = 0; c < 3; c++)
        led_q[c] <= (pwm_cnt_q < shadow_q[(2-c)*PWM_BITS +: PWM_BITS]) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm_fader.sv
// Directed bench for rgb_led_pwm_fader: an active-high and an active-low build
// share the same command stream.
module tb_rgb_led_pwm_fader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [23:0] cmd_rgb;
  logic        cmd_fade;
  logic        cmd_ready, busy;
  logic [23:0] cur_rgb;
  logic [2:0]  led_rgb;
  logic        cmd_ready_n, busy_n;
  logic [23:0] cur_rgb_n;
  logic [2:0]  led_rgb_n;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  rgb_led_pwm_fader #(.PWM_BITS(8), .PRESCALE(4), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rgb(cmd_rgb), .cmd_fade(cmd_fade), .busy(busy), .cur_rgb(cur_rgb),
    .led_rgb(led_rgb)
  );

  rgb_led_pwm_fader #(.PWM_BITS(8), .PRESCALE(4), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_n),
    .cmd_rgb(cmd_rgb), .cmd_fade(cmd_fade), .busy(busy_n), .cur_rgb(cur_rgb_n),
    .led_rgb(led_rgb_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] rgb, input logic fade);
    cmd_valid = 1'b1;
    cmd_rgb   = rgb;
    cmd_fade  = fade;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic count_window(output int unsigned hi[3], output int unsigned lo_n[3]);
    for (int unsigned c = 0; c < 3; c++) begin
      hi[c]   = 0;
      lo_n[c] = 0;
    end
    for (int i = 0; i < 256; i++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (led_rgb[c])    hi[c]++;
        if (!led_rgb_n[c]) lo_n[c]++;
      end
      tick();
    end
  endtask

  int unsigned hi[3];
  int unsigned lo_n[3];
  int unsigned r, g;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_rgb   = '0;
    cmd_fade  = 1'b0;

    // Reset held
    repeat (10) tick();
    check("rst_led",     {29'd0, led_rgb},   32'h0);
    check("rst_led_al",  {29'd0, led_rgb_n}, 32'h7);
    check("rst_ready",   {31'd0, cmd_ready}, 32'h1);
    check("rst_busy",    {31'd0, busy},      32'h0);
    check("rst_cur",     {8'd0, cur_rgb},    32'h0);
    rst_n = 1'b1;
    tick();

    // Immediate apply and PWM duty
    send(24'h8000FF, 1'b0);
    check("imm_cur",     {8'd0, cur_rgb},    32'h8000FF);
    check("imm_busy",    {31'd0, busy},      32'h0);
    repeat (260) tick();
    count_window(hi, lo_n);
    check("pwm_r_hi",    hi[0],   32'd128);
    check("pwm_g_hi",    hi[1],   32'd0);
    check("pwm_b_hi",    hi[2],   32'd255);
    check("pwm_al_r_lo", lo_n[0], 32'd128);
    check("pwm_al_g_lo", lo_n[1], 32'd0);
    check("pwm_al_b_lo", lo_n[2], 32'd255);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_cur",    {8'd0, cur_rgb},    32'h0);
    check("arst_led",    {29'd0, led_rgb},   32'h0);
    check("arst_led_al", {29'd0, led_rgb_n}, 32'h7);
    check("arst_ready",  {31'd0, cmd_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // Fade 0 -> {04,02,00}
    send(24'h040200, 1'b1);
    check("f1_busy0",    {31'd0, busy},      32'h1);
    check("f1_ready0",   {31'd0, cmd_ready}, 32'h0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      r = (k / 4 > 4) ? 4 : k / 4;
      g = (k / 4 > 2) ? 2 : k / 4;
      check($sformatf("f1_cur_k%0d", k), {8'd0, cur_rgb}, (r << 16) | (g << 8));
      check($sformatf("f1_busy_k%0d", k), {31'd0, busy}, (k < 17) ? 32'h1 : 32'h0);
    end
    check("f1_ready_end", {31'd0, cmd_ready}, 32'h1);

    // Mixed-direction fade {10,00,05} -> {0E,02,05}
    send(24'h100005, 1'b0);
    check("f2_start",    {8'd0, cur_rgb},    32'h100005);
    send(24'h0E0205, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      g = (k / 4 > 2) ? 2 : k / 4;
      check($sformatf("f2_cur_k%0d", k), {8'd0, cur_rgb}, ((32'h10 - g) << 16) | (g << 8) | 32'h05);
      check($sformatf("f2_busy_k%0d", k), {31'd0, busy}, (k < 9) ? 32'h1 : 32'h0);
    end

    // cmd_valid held through a fade
    cmd_valid = 1'b1;
    cmd_rgb   = 24'h110205;
    cmd_fade  = 1'b1;
    tick();
    cmd_rgb   = 24'h203040;
    cmd_fade  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      r = (k / 4 > 3) ? 3 : k / 4;
      check($sformatf("hold_cur_k%0d", k), {8'd0, cur_rgb}, ((32'h0E + r) << 16) | 32'h0205);
      check($sformatf("hold_ready_k%0d", k), {31'd0, cmd_ready}, 32'h0);
    end
    tick();
    check("hold_idle_ready", {31'd0, cmd_ready}, 32'h1);
    check("hold_idle_cur",   {8'd0, cur_rgb},    32'h110205);
    tick();
    check("hold_accept",     {8'd0, cur_rgb},    32'h203040);
    cmd_valid = 1'b0;

    // Fade to the current colour is a no-op
    send(24'h203040, 1'b1);
    check("eq_busy0",    {31'd0, busy},      32'h0);
    check("eq_ready0",   {31'd0, cmd_ready}, 32'h1);
    tick();
    check("eq_busy1",    {31'd0, busy},      32'h0);
    check("eq_cur",      {8'd0, cur_rgb},    32'h203040);

    // Reset mid-fade after step 2 of 4
    send(24'h243040, 1'b1);
    repeat (8) tick();
    check("mid_cur",     {8'd0, cur_rgb},    32'h223040);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cur",   {8'd0, cur_rgb},    32'h0);
    check("mid_rst_busy",  {31'd0, busy},      32'h0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    send(24'h020000, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      r = (k / 4 > 2) ? 2 : k / 4;
      check($sformatf("post_cur_k%0d", k), {8'd0, cur_rgb}, r << 16);
    end
    check("post_busy",   {31'd0, busy},      32'h0);
    check("post_al_cur", {8'd0, cur_rgb_n},  32'h020000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
